// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM state codes, mux
// select codes and the per-state control word.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    // Moore output decode; unused codes fall through to an all-zero word.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                c.alu_src_a  = SRCA_REG;
                c.alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_w      = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = 1'b1;
            end
            S_EXECI: begin
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURESULT;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle ARM main controller FSM with registered Moore outputs and a
// retired-instruction counter.
module main_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl_q, ctrl_d;

    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_comb begin
        state_d   = S_FETCH;
        retired_d = retired_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
        // An instruction retires on the edge leaving its final state.
        if (state_q == S_MEMWB || state_q == S_MEMWR ||
            state_q == S_ALUWB || state_q == S_BRANCH) begin
            retired_d = retired_q + CNT_W'(1);
        end
        ctrl_d = ctrl_for(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            ctrl_q    <= ctrl_for(S_FETCH);
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign IRWrite   = ctrl_q.ir_write;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ResultSrc = ctrl_q.result_src;
    assign NextPC    = ctrl_q.next_pc;
    assign RegW      = ctrl_q.reg_w;
    assign MemW      = ctrl_q.mem_w;
    assign Branch    = ctrl_q.branch;
    assign ALUOp     = ctrl_q.alu_op;
    assign State     = state_q;
    assign Retired   = retired_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: state sequences, per-state outputs, retire
// counting, mid-instruction reset and counter wrap (narrow instance).
module tb_main_fsm;

    logic        clk;
    logic        reset;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  State;
    logic [31:0] Retired;

    logic        w_reset;
    logic        w_irwrite, w_adrsrc, w_nextpc, w_regw, w_memw, w_branch, w_aluop;
    logic [1:0]  w_srca, w_srcb, w_res;
    logic [3:0]  w_state;
    logic [3:0]  w_retired;

    int checks;
    int failures;

    main_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .State(State), .Retired(Retired)
    );

    main_fsm #(.CNT_W(4)) dut_w (
        .clk(clk), .reset(w_reset), .Op(Op), .Funct(Funct),
        .IRWrite(w_irwrite), .AdrSrc(w_adrsrc), .ALUSrcA(w_srca), .ALUSrcB(w_srcb),
        .ResultSrc(w_res), .NextPC(w_nextpc), .RegW(w_regw), .MemW(w_memw),
        .Branch(w_branch), .ALUOp(w_aluop), .State(w_state), .Retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
    function automatic logic [12:0] exp_out(input logic [3:0] s);
        case (s)
            4'd0:    return 13'b1_0_01_10_10_1_0000;
            4'd1:    return 13'b0_0_01_10_10_0_0000;
            4'd2:    return 13'b0_0_00_01_00_0_0000;
            4'd3:    return 13'b0_1_00_00_00_0_0000;
            4'd4:    return 13'b0_0_00_00_01_0_1000;
            4'd5:    return 13'b0_1_00_00_00_0_0100;
            4'd6:    return 13'b0_0_00_00_00_0_0001;
            4'd7:    return 13'b0_0_00_01_00_0_0001;
            4'd8:    return 13'b0_0_00_00_00_0_1000;
            4'd9:    return 13'b0_0_00_01_10_0_0010;
            default: return 13'b0;
        endcase
    endfunction

    function automatic logic [12:0] act_out();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
                RegW, MemW, Branch, ALUOp};
    endfunction

    // Walks one instruction from FETCH to the next FETCH. seq holds the
    // expected states, first in the low nibble. Inputs carry the real
    // opcode only where the FSM samples them; elsewhere they are scrambled.
    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] f, input logic [23:0] seq,
                             input int n, input logic [31:0] exp_ret);
        logic [3:0] st;
        for (int i = 0; i < n; i++) begin
            st = seq[4*i +: 4];
            if (st == 4'd1 || st == 4'd2) begin
                Op    = op;
                Funct = f;
            end else begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            checks++;
            if (State !== st) begin
                failures++;
                $display("FAIL %s state[%0d]: got %0d expected %0d", name, i, State, st);
            end
            checks++;
            if (act_out() !== exp_out(st)) begin
                failures++;
                $display("FAIL %s outputs[%0d] state %0d: got %b expected %b",
                         name, i, st, act_out(), exp_out(st));
            end
            if (i < n - 1) @(negedge clk);
        end
        checks++;
        if (Retired !== exp_ret) begin
            failures++;
            $display("FAIL %s retired: got %0d expected %0d", name, Retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Op    = 2'b11;
        Funct = 6'h3f;
        repeat (3) @(negedge clk);
        checks++;
        if (State !== 4'd0 || Retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got state %0d retired %0d expected 0 0", State, Retired);
        end
        checks++;
        if (IRWrite !== 1'b1 || NextPC !== 1'b1 || act_out() !== exp_out(4'd0)) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", act_out(), exp_out(4'd0));
        end
        reset = 1'b0;
    endtask

    task automatic test_ldr();
        run_instr("ldr", 2'b01, 6'b011001, {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 6, 32'd1);
    endtask

    task automatic test_str();
        run_instr("str", 2'b01, 6'b011000, {4'd0, 4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 5, 32'd2);
    endtask

    task automatic test_dp();
        run_instr("add_imm", 2'b00, 6'b101000, {4'd0, 4'd0, 4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, 5, 32'd3);
        run_instr("add_reg", 2'b00, 6'b001000, {4'd0, 4'd0, 4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 5, 32'd4);
    endtask

    task automatic test_branch_illegal();
        run_instr("branch", 2'b10, 6'b000000, {4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 4, 32'd5);
        run_instr("illegal", 2'b11, 6'b111111, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 3, 32'd5);
    endtask

    task automatic test_reset_mid();
        Op    = 2'b01;
        Funct = 6'b011001;
        repeat (3) @(negedge clk);
        checks++;
        if (State !== 4'd3) begin
            failures++;
            $display("FAIL mid_reach_memrd: got %0d expected 3", State);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (State !== 4'd0 || Retired !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: got state %0d retired %0d expected 0 0", State, Retired);
        end
        // Back-to-back branch right after the abandoned load.
        run_instr("post_reset_b", 2'b10, 6'b000000, {4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 4, 32'd1);
    endtask

    task automatic test_wrap();
        Op    = 2'b10;
        Funct = 6'b000000;
        w_reset = 1'b0;
        repeat (45) @(negedge clk);
        checks++;
        if (w_retired !== 4'd15 || w_state !== 4'd0) begin
            failures++;
            $display("FAIL wrap_pre: got retired %0d state %0d expected 15 0", w_retired, w_state);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (w_retired !== 4'd0 || w_state !== 4'd0) begin
            failures++;
            $display("FAIL wrap: got retired %0d state %0d expected 0 0", w_retired, w_state);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        w_reset  = 1'b1;
        Op       = 2'b00;
        Funct    = 6'b000000;
        test_reset();
        test_ldr();
        test_str();
        test_dp();
        test_branch_illegal();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
